// File: rtl/yin_pkg.sv
// Shared definitions for the YIN lag search and its difference engine:
// state encoding, default threshold and the widths both blocks agree on.
package yin_pkg;

  localparam int YIN_IDW      = 64;
  localparam int YIN_TAU_W    = 6;
  localparam int YIN_THRESH_W = 8;
  localparam int YIN_MAX_TAU  = 40;

  // 0x26 / 256 ~= 0.15
  localparam logic [7:0] YIN_DEFAULT_THRESHOLD = 8'h26;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DONE   = 3'd4
  } yin_state_e;

  function automatic int yin_prod_width(input int idw, input int tw, input int thw);
    return idw + tw + thw;
  endfunction

endpackage

// File: rtl/yin_tau_search_cmnd_compare.sv
// Division-free cumulative-mean-normalised-difference test:
// hit when d*tau*2^THW < threshold*running_sum, all at full product width.
module cmnd_compare
  import yin_pkg::*;
#(
  parameter int IDW = YIN_IDW,
  parameter int TW  = YIN_TAU_W,
  parameter int THW = YIN_THRESH_W
) (
  input  logic [IDW-1:0]    d,
  input  logic [TW-1:0]     tau,
  input  logic [IDW+TW-1:0] sum_new,
  input  logic [THW-1:0]    threshold,
  output logic              hit
);

  localparam int PW = yin_prod_width(IDW, TW, THW);

  logic [PW-1:0] lhs;
  logic [PW-1:0] rhs;

  always_comb begin
    lhs = (PW'(d) * PW'(tau)) << THW;
    rhs = PW'(threshold) * PW'(sum_new);
    hit = (lhs < rhs);
  end

endmodule

// File: rtl/yin_tau_search.sv
// YIN lag search: steps tau through the difference engine and stops at the
// first lag whose normalised difference falls below threshold.
// Optional WAIT watchdog enabled by defining YIN_WAIT_TIMEOUT_EN.
module yin_tau_search
  import yin_pkg::*;
#(
  parameter int INTERMEDIATE_DATA_WIDTH = YIN_IDW,
  parameter int MAX_TAU                 = YIN_MAX_TAU,
  parameter int TAU_WIDTH               = YIN_TAU_W,
  parameter int THRESH_WIDTH            = YIN_THRESH_W,
  parameter int WAIT_TIMEOUT            = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [THRESH_WIDTH-1:0]            threshold,
  output logic [TAU_WIDTH-1:0]               diff_tau,
  output logic                               diff_reset,
  input  logic                               diff_ready,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0] diff_acc,
  output logic                               busy,
  output logic                               done,
  output logic                               pitch_valid,
  output logic [TAU_WIDTH-1:0]               tau_out
`ifdef YIN_WAIT_TIMEOUT_EN
  ,
  output logic                               timeout_err
`endif
);

  localparam int SW = INTERMEDIATE_DATA_WIDTH + TAU_WIDTH;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_EVAL   = ST_EVAL;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam logic [TAU_WIDTH-1:0] LAST_TAU = TAU_WIDTH'(MAX_TAU);

  logic [2:0]                         state_q, state_d;
  logic [TAU_WIDTH-1:0]               tau_q, tau_d;
  logic [SW-1:0]                      sum_q, sum_d;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] d_q, d_d;
  logic [THRESH_WIDTH-1:0]            thr_q, thr_d;
  logic                               pv_q, pv_d;
  logic [TAU_WIDTH-1:0]               tau_out_q, tau_out_d;

  logic [SW-1:0] sum_new;
  logic          hit;

`ifdef YIN_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  assign timeout_err = terr_q;
`else
  // The watchdog limit only matters when the watchdog is built in.
  logic [31:0] unused_wait_timeout;
  assign unused_wait_timeout = 32'(WAIT_TIMEOUT);
`endif

  assign sum_new = sum_q + SW'(d_q);

  cmnd_compare #(
    .IDW (INTERMEDIATE_DATA_WIDTH),
    .TW  (TAU_WIDTH),
    .THW (THRESH_WIDTH)
  ) u_cmnd_compare (
    .d         (d_q),
    .tau       (tau_q),
    .sum_new   (sum_new),
    .threshold (thr_q),
    .hit       (hit)
  );

  always_comb begin
    state_d   = state_q;
    tau_d     = tau_q;
    sum_d     = sum_q;
    d_d       = d_q;
    thr_d     = thr_q;
    pv_d      = pv_q;
    tau_out_d = tau_out_q;
`ifdef YIN_WAIT_TIMEOUT_EN
    cnt_d     = cnt_q;
    terr_d    = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LAUNCH;
          tau_d     = TAU_WIDTH'(1);
          sum_d     = '0;
          thr_d     = threshold;
          pv_d      = 1'b0;
          tau_out_d = '0;
`ifdef YIN_WAIT_TIMEOUT_EN
          terr_d    = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef YIN_WAIT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (diff_ready) begin
          d_d     = diff_acc;
          state_d = S_EVAL;
        end
`ifdef YIN_WAIT_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          pv_d      = 1'b0;
          tau_out_d = '0;
          terr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_EVAL: begin
        if (hit) begin
          pv_d      = 1'b1;
          tau_out_d = tau_q;
          state_d   = S_DONE;
        end else if (tau_q >= LAST_TAU) begin
          pv_d      = 1'b0;
          tau_out_d = '0;
          state_d   = S_DONE;
        end else begin
          sum_d   = sum_new;
          tau_d   = tau_q + TAU_WIDTH'(1);
          state_d = S_LAUNCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tau_q     <= '0;
      sum_q     <= '0;
      d_q       <= '0;
      thr_q     <= '0;
      pv_q      <= 1'b0;
      tau_out_q <= '0;
`ifdef YIN_WAIT_TIMEOUT_EN
      cnt_q     <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tau_q     <= tau_d;
      sum_q     <= sum_d;
      d_q       <= d_d;
      thr_q     <= thr_d;
      pv_q      <= pv_d;
      tau_out_q <= tau_out_d;
`ifdef YIN_WAIT_TIMEOUT_EN
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
`endif
    end
  end

  // The engine is held in restart everywhere except while it is computing
  // or its held result is being evaluated.
  assign diff_reset  = (state_q != S_WAIT) && (state_q != S_EVAL);
  assign diff_tau    = tau_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign pitch_valid = pv_q;
  assign tau_out     = tau_out_q;

endmodule

// File: doc/yin_tau_search.md
YIN_TAU_SEARCH -- requirements
Module: yin_tau_search

Interface
REQ-001 SHALL have parameter INTERMEDIATE_DATA_WIDTH, default 64: width of difference-engine sum d(tau).
REQ-002 SHALL have parameter MAX_TAU, default 40: last lag evaluated.
REQ-003 SHALL have parameter TAU_WIDTH, default 6: lag width, matching the difference engine's tau port.
REQ-004 SHALL have parameter THRESH_WIDTH, default 8: threshold width, unsigned fraction Q0.THRESH_WIDTH.
REQ-005 SHALL have parameter WAIT_TIMEOUT, default 1024: watchdog limit in cycles, used only under REQ-025.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 start  in  1  begin lag search; sampled in IDLE only.
REQ-009 threshold  in  THRESH_WIDTH  YIN absolute threshold; sampled on accepted start.
REQ-010 diff_tau  out  TAU_WIDTH  lag presented to the difference engine.
REQ-011 diff_reset  out  1  active-high restart for the difference engine.
REQ-012 diff_ready  in  1  engine result valid; level, held until next diff_reset.
REQ-013 diff_acc  in  INTERMEDIATE_DATA_WIDTH  engine sum d(diff_tau).
REQ-014 busy  out  1  high from LAUNCH through DONE.
REQ-015 done  out  1  one-cycle pulse at search end.
REQ-016 pitch_valid  out  1  a lag met the threshold.
REQ-017 tau_out  out  TAU_WIDTH  detected lag; 0 when pitch_valid=0.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT, EVAL, DONE.
- IDLE: diff_reset=1, busy=0. On start=1: tau=1, running_sum=0, latch threshold, go to LAUNCH.
- LAUNCH: one cycle, diff_reset=1, diff_tau=tau; go to WAIT.
- WAIT: diff_reset=0; first cycle with diff_ready=1: capture diff_acc into d, go to EVAL.
- EVAL: one cycle (see REQ-019..021).
- DONE: one cycle, done=1; go to IDLE.
REQ-019 EVAL SHALL compute sum_new = running_sum + d, full width INTERMEDIATE_DATA_WIDTH+TAU_WIDTH, with no truncation.
REQ-020 EVAL SHALL test the CMND without division.
- Condition: d*tau*2^THRESH_WIDTH < threshold*sum_new.
- Both products use full width INTERMEDIATE_DATA_WIDTH+TAU_WIDTH+THRESH_WIDTH.
- Strict less-than.
REQ-021 EVAL outcome:
- Hit: tau_out=tau, pitch_valid=1, go to DONE.
- Miss at tau==MAX_TAU: tau_out=0, pitch_valid=0, go to DONE.
- Otherwise: running_sum=sum_new, tau+1, go to LAUNCH.
REQ-022 Boundary behaviour:
- All-zero d (silence) SHALL yield pitch_valid=0, since 0<0 is false.
- start while busy SHALL be ignored.
- start held high SHALL begin a new search on the cycle after DONE.
- diff_tau SHALL never exceed MAX_TAU.
REQ-023 tau_out and pitch_valid SHALL hold from DONE until the next accepted start, then clear to 0 on that start.

Reset
REQ-024 With reset=0 at a rising edge, on any state (including mid-WAIT), the block SHALL set:
- state IDLE
- diff_reset=1, diff_tau=0
- busy=0, done=0
- pitch_valid=0, tau_out=0
- running_sum=0, d=0

Configuration
REQ-025 Macro YIN_WAIT_TIMEOUT_EN SHALL control the WAIT watchdog.
- Defined: add output timeout_err (1 bit, reset 0) and a counter cleared in LAUNCH.
- Defined: if WAIT lasts WAIT_TIMEOUT cycles without diff_ready, go to DONE with pitch_valid=0, tau_out=0, timeout_err=1.
- Defined: timeout_err holds until the next accepted start.
- Undefined: no port and no counter; WAIT waits indefinitely.

Structure
REQ-026 Shared package yin_pkg SHALL hold:
- the state enum
- default threshold constant 8'h26 (about 0.15)
- width constants shared with the difference engine
REQ-027 The comparison in REQ-020 SHALL be a combinational sub-module named cmnd_compare.

Verification
REQ-028 The bench SHALL use a behavioural engine model with 256-cycle ready latency after diff_reset falls, and SHALL cover:
- d=1000 for all tau, threshold=0x26 -> 40 launches, one done pulse, pitch_valid=0, tau_out=0.
- d=1000 except d(10)=10, threshold=0x26 -> check 25600<342380 is a hit -> tau_out=10, pitch_valid=1, max diff_tau=10.
- d=0 for all tau -> pitch_valid=0 after tau 40.
- reset=0 for one cycle during WAIT at tau=5 -> next cycle busy=0, diff_reset=1; a later start restarts at diff_tau=1.
- start pulsed during busy -> ignored; start held high -> two back-to-back searches, two done pulses.
- YIN_WAIT_TIMEOUT_EN, WAIT_TIMEOUT=1000, model never readies -> done with timeout_err=1 1000 cycles after entering WAIT.
